multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clock  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-003 SHALL have port run  input  1  enable; when low, no new fetch starts.
REQ-004 SHALL have port instr_op  input  6  opcode field of fetched word; valid when mem_ready is high in IF.
REQ-005 SHALL have port instr_fn  input  6  function field of fetched word; valid when mem_ready is high in IF.
REQ-006 SHALL have port zero  input  1  ALU zero flag; sampled combinationally in EX.
REQ-007 SHALL have port mem_ready  input  1  memory completes the current access.
REQ-008 SHALL have the following 1-bit outputs: ir_write, pc_write, mem_read, mem_write, reg_write, alu_src, i_format, sftmd, jr, instr_done, illegal.
REQ-009 SHALL have port pc_src  output  2  next-PC select: 0=PC+4, 1=branch, 2=register (jr), 3=jump.
REQ-010 SHALL have port alu_op  output  2  ALU operation class: 00=add, 01=sub/compare, 10=funct/opcode decode.
REQ-011 SHALL have port state  output  3  current FSM state code.
REQ-012 SHALL have port retired  output  32  count of completed instructions.

Function
REQ-013 SHALL implement the following states: IF=0, ID=1, EX=2, MEM=3, WB=4.
REQ-014 SHALL drive every output as a function of the current state and the latched op/fn only, except for the uses of zero and mem_ready given below; non-listed outputs SHALL be 0.
REQ-015 In IF, when run=1, SHALL drive mem_read=1 and remain in IF until mem_ready=1.
REQ-016 In IF, on the mem_ready cycle, SHALL drive ir_write=1, pc_write=1 and pc_src=0, latch instr_op and instr_fn, and transition to ID.
REQ-017 In IF, when run=0, SHALL drive all outputs to 0 and remain in IF; a run deassertion in any other state SHALL let the current instruction finish.
REQ-018 ID SHALL last exactly 1 cycle with all outputs 0, then transition to EX.
REQ-019 EX, R-type (op=000000, fn!=001000): alu_op=10, alu_src=0, sftmd=1 when fn[5:3]=000; next state WB.
REQ-020 EX, jr (op=000000, fn=001000): jr=1, pc_write=1, pc_src=2; next state IF; instr_done=1.
REQ-021 EX, beq (000100): alu_op=01, pc_src=1, pc_write=zero; next state IF; instr_done=1.
REQ-022 EX, bne (000101): alu_op=01, pc_src=1, pc_write=!zero; next state IF; instr_done=1.
REQ-023 EX, j (000010): pc_write=1, pc_src=3; next state IF; instr_done=1.
REQ-024 EX, jal (000011): pc_write=1, pc_src=3; next state WB.
REQ-025 EX, lw (100011) or sw (101011): alu_src=1, alu_op=00; next state MEM.
REQ-026 EX, I-arith (op[5:3]=001): alu_src=1, i_format=1, alu_op=10; next state WB.
REQ-027 EX, any other op: illegal=1 for 1 cycle, no write strobes; next state IF; instr_done SHALL NOT assert and retired SHALL NOT increment.
REQ-028 MEM: lw SHALL drive mem_read=1 and sw SHALL drive mem_write=1, held until mem_ready=1.
REQ-029 MEM exit: on the mem_ready cycle, lw SHALL transition to WB; sw SHALL transition to IF with instr_done=1.
REQ-030 WB SHALL drive reg_write=1 for exactly 1 cycle and instr_done=1, then transition to IF.
REQ-031 retired SHALL increment by 1 on each cycle with instr_done=1, SHALL wrap from 0xFFFFFFFF to 0, and SHALL update on the clock edge ending that cycle.
REQ-032 Undefined state encodings SHALL transition to IF on the next edge.

Reset
REQ-033 While reset=0, SHALL set state=IF, retired=0, latched op/fn=0, and all strobes to 0, regardless of clock.
REQ-034 A reset assertion mid-instruction (including during a MEM wait) SHALL abort it; no further strobes SHALL issue until run=1 after release.

Verification
REQ-035 Scenario: add (op=0, fn=100000), mem_ready on first IF cycle -> states IF,ID,EX,WB; reg_write in cycle 4; retired 0->1.
REQ-036 Scenario: lw with mem_ready delayed 3 cycles in IF and 2 cycles in MEM -> 10 cycles IF-to-WB; mem_read held throughout both waits.
REQ-037 Scenario: beq with zero=1, then zero=0 -> pc_write=1 with pc_src=1 in the first case; pc_write=0 in the second; both retire.
REQ-038 Scenario: op=111111 -> illegal pulses once, no strobes, retired unchanged, returns to IF.
REQ-039 Scenario: reset low during MEM of sw -> mem_write drops immediately, state=0, retired=0.
REQ-040 Scenario: preload retired=0xFFFFFFFF by forcing, then retire j -> retired=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multicycle controller and its datapath/memory.
// The master side is the controller; the slave side is the datapath and memory environment.
interface multicycle_ctrl_if;
    logic        run;
    logic [5:0]  instr_op;
    logic [5:0]  instr_fn;
    logic        zero;
    logic        mem_ready;

    logic        ir_write;
    logic        pc_write;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        alu_src;
    logic        i_format;
    logic        sftmd;
    logic        jr;
    logic        instr_done;
    logic        illegal;
    logic [1:0]  pc_src;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] retired;

    modport master (
        input  run, instr_op, instr_fn, zero, mem_ready,
        output ir_write, pc_write, mem_read, mem_write, reg_write, alu_src,
               i_format, sftmd, jr, instr_done, illegal, pc_src, alu_op,
               state, retired
    );

    modport slave (
        output run, instr_op, instr_fn, zero, mem_ready,
        input  ir_write, pc_write, mem_read, mem_write, reg_write, alu_src,
               i_format, sftmd, jr, instr_done, illegal, pc_src, alu_op,
               state, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Five-state multicycle CPU controller (IF/ID/EX/MEM/WB) with a retired-instruction counter.
// Strobes are decoded from the current state and latched opcode, plus mem_ready/zero/run where needed.
module multicycle_ctrl (
    input  logic             clock,
    input  logic             reset,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  op_q, fn_q;
    logic [31:0] retired_q;

    logic        isRtype, isJr, isBeq, isBne, isJ, isJal, isLw, isSw, isIarith;
    logic        latchInstr;
    logic        irWrite, pcWrite, memRead, memWrite, regWrite, aluSrc;
    logic        iFormat, sftmd, jrSel, instrDone, illegal;
    logic [1:0]  pcSrc, aluOp;

    assign isRtype  = (op_q == 6'b000000);
    assign isJr     = isRtype && (fn_q == 6'b001000);
    assign isBeq    = (op_q == 6'b000100);
    assign isBne    = (op_q == 6'b000101);
    assign isJ      = (op_q == 6'b000010);
    assign isJal    = (op_q == 6'b000011);
    assign isLw     = (op_q == 6'b100011);
    assign isSw     = (op_q == 6'b101011);
    assign isIarith = (op_q[5:3] == 3'b001);

    always_comb begin
        state_d    = state_q;
        latchInstr = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        regWrite   = 1'b0;
        aluSrc     = 1'b0;
        iFormat    = 1'b0;
        sftmd      = 1'b0;
        jrSel      = 1'b0;
        instrDone  = 1'b0;
        illegal    = 1'b0;
        pcSrc      = 2'd0;
        aluOp      = 2'b00;
        case (state_q)
            S_IF: begin
                if (bus.run) begin
                    memRead = 1'b1;
                    if (bus.mem_ready) begin
                        irWrite    = 1'b1;
                        pcWrite    = 1'b1;
                        latchInstr = 1'b1;
                        state_d    = S_ID;
                    end
                end
            end
            S_ID: state_d = S_EX;
            S_EX: begin
                // jr shares the R-type opcode, so it must be recognised first.
                if (isJr) begin
                    jrSel     = 1'b1;
                    pcWrite   = 1'b1;
                    pcSrc     = 2'd2;
                    instrDone = 1'b1;
                    state_d   = S_IF;
                end else if (isRtype) begin
                    aluOp   = 2'b10;
                    sftmd   = (fn_q[5:3] == 3'b000);
                    state_d = S_WB;
                end else if (isBeq || isBne) begin
                    aluOp     = 2'b01;
                    pcSrc     = 2'd1;
                    pcWrite   = isBeq ? bus.zero : !bus.zero;
                    instrDone = 1'b1;
                    state_d   = S_IF;
                end else if (isJ || isJal) begin
                    pcWrite   = 1'b1;
                    pcSrc     = 2'd3;
                    instrDone = isJ;
                    state_d   = isJ ? S_IF : S_WB;
                end else if (isLw || isSw) begin
                    aluSrc  = 1'b1;
                    state_d = S_MEM;
                end else if (isIarith) begin
                    aluSrc  = 1'b1;
                    iFormat = 1'b1;
                    aluOp   = 2'b10;
                    state_d = S_WB;
                end else begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                memRead  = isLw;
                memWrite = !isLw;
                if (bus.mem_ready) begin
                    instrDone = !isLw;
                    state_d   = isLw ? S_WB : S_IF;
                end
            end
            S_WB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
                state_d   = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IF;
            op_q      <= 6'd0;
            fn_q      <= 6'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_q + {31'd0, instrDone};
            if (latchInstr) begin
                op_q <= bus.instr_op;
                fn_q <= bus.instr_fn;
            end
        end
    end

    // Reset is asynchronous, so strobes are also masked combinationally while it is held.
    assign bus.ir_write   = irWrite   && reset;
    assign bus.pc_write   = pcWrite   && reset;
    assign bus.mem_read   = memRead   && reset;
    assign bus.mem_write  = memWrite  && reset;
    assign bus.reg_write  = regWrite  && reset;
    assign bus.alu_src    = aluSrc    && reset;
    assign bus.i_format   = iFormat   && reset;
    assign bus.sftmd      = sftmd     && reset;
    assign bus.jr         = jrSel     && reset;
    assign bus.instr_done = instrDone && reset;
    assign bus.illegal    = illegal   && reset;
    assign bus.pc_src     = pcSrc & {2{reset}};
    assign bus.alu_op     = aluOp & {2{reset}};
    assign bus.state      = state_q;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle strobe trace from the instruction's class, then replayed against the DUT.
module tb_multicycle_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [17:0] IRW  = 18'h20000;
    localparam logic [17:0] PCW  = 18'h10000;
    localparam logic [17:0] MRD  = 18'h08000;
    localparam logic [17:0] MWR  = 18'h04000;
    localparam logic [17:0] RGW  = 18'h02000;
    localparam logic [17:0] ASRC = 18'h01000;
    localparam logic [17:0] IFMT = 18'h00800;
    localparam logic [17:0] SFT  = 18'h00400;
    localparam logic [17:0] JRB  = 18'h00200;
    localparam logic [17:0] DONE = 18'h00100;
    localparam logic [17:0] ILL  = 18'h00080;

    typedef struct {
        logic        run;
        logic        rdy;
        logic        zr;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [17:0] exp;
    } cyc_t;

    cyc_t        plan[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelRetired = 32'd0;
    logic [17:0] obsVec;

    assign obsVec = {bus.ir_write, bus.pc_write, bus.mem_read, bus.mem_write, bus.reg_write,
                     bus.alu_src, bus.i_format, bus.sftmd, bus.jr, bus.instr_done,
                     bus.illegal, bus.pc_src, bus.alu_op, bus.state};

    function automatic logic [17:0] st(input int s);
        return 18'(s);
    endfunction

    function automatic logic [17:0] pcs(input int v);
        return 18'(v << 5);
    endfunction

    function automatic logic [17:0] aop(input int v);
        return 18'(v << 3);
    endfunction

    task automatic checkOutput(input string tag, input logic [17:0] exp);
        checks++;
        assert (obsVec === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obsVec, exp);
        end
    endtask

    task automatic checkRetired(input string tag);
        checks++;
        assert (bus.retired === modelRetired)
        else begin
            errors++;
            $error("[TB] FAIL %s retired: observed %h expected %h", tag, bus.retired, modelRetired);
        end
    endtask

    task automatic pushCycle(input logic r, input logic rdy, input logic zr,
                             input logic [5:0] op, input logic [5:0] fn, input logic [17:0] exp);
        cyc_t c;
        c.run = r; c.rdy = rdy; c.zr = zr; c.op = op; c.fn = fn; c.exp = exp;
        plan.push_back(c);
    endtask

    // Expected trace of one instruction, derived from its class and the wait counts.
    task automatic planInstr(input logic [5:0] op, input logic [5:0] fn, input int ifWait,
                             input int memWait, input logic zr, input logic randRun);
        logic        r;
        logic        isLw, isSw;
        logic [17:0] e;
        int          nxt;
        isLw = (op == 6'b100011);
        isSw = (op == 6'b101011);
        for (int i = 0; i < ifWait; i++) begin
            r = randRun ? 1'($urandom) : 1'b1;
            pushCycle(r, r ? 1'b0 : 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom),
                      r ? (MRD | st(0)) : st(0));
        end
        pushCycle(1'b1, 1'b1, 1'($urandom), op, fn, IRW | PCW | MRD | st(0));
        r = randRun ? 1'($urandom) : 1'b1;
        pushCycle(r, 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), st(1));
        if (op == 6'd0 && fn == 6'b001000) begin
            e = JRB | PCW | pcs(2) | DONE; nxt = 0;
        end else if (op == 6'd0) begin
            e = aop(2) | ((fn[5:3] == 3'b000) ? SFT : 18'd0); nxt = 4;
        end else if (op == 6'b000100) begin
            e = aop(1) | pcs(1) | (zr ? PCW : 18'd0) | DONE; nxt = 0;
        end else if (op == 6'b000101) begin
            e = aop(1) | pcs(1) | (zr ? 18'd0 : PCW) | DONE; nxt = 0;
        end else if (op == 6'b000010) begin
            e = PCW | pcs(3) | DONE; nxt = 0;
        end else if (op == 6'b000011) begin
            e = PCW | pcs(3); nxt = 4;
        end else if (isLw || isSw) begin
            e = ASRC; nxt = 3;
        end else if (op[5:3] == 3'b001) begin
            e = ASRC | IFMT | aop(2); nxt = 4;
        end else begin
            e = ILL; nxt = 0;
        end
        r = randRun ? 1'($urandom) : 1'b1;
        pushCycle(r, 1'($urandom), zr, 6'($urandom), 6'($urandom), e | st(2));
        if (nxt == 3) begin
            for (int i = 0; i < memWait; i++) begin
                r = randRun ? 1'($urandom) : 1'b1;
                pushCycle(r, 1'b0, 1'($urandom), 6'($urandom), 6'($urandom),
                          (isLw ? MRD : MWR) | st(3));
            end
            r = randRun ? 1'($urandom) : 1'b1;
            pushCycle(r, 1'b1, 1'($urandom), 6'($urandom), 6'($urandom),
                      (isLw ? MRD : (MWR | DONE)) | st(3));
            if (isLw) nxt = 4;
        end
        if (nxt == 4) begin
            r = randRun ? 1'($urandom) : 1'b1;
            pushCycle(r, 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), RGW | DONE | st(4));
        end
    endtask

    // Replays the planned cycles; maxCycles < 0 drains the plan and finishes with an idle check.
    task automatic applyStimulus(input string tag, input int maxCycles);
        cyc_t c;
        int   n = 0;
        while (plan.size() > 0 && (maxCycles < 0 || n < maxCycles)) begin
            c = plan.pop_front();
            @(negedge clock);
            bus.run = c.run; bus.mem_ready = c.rdy; bus.zero = c.zr;
            bus.instr_op = c.op; bus.instr_fn = c.fn;
            #1;
            checkOutput(tag, c.exp);
            checkRetired(tag);
            if ((c.exp & DONE) != 18'd0) modelRetired = modelRetired + 32'd1;
            n++;
        end
        if (maxCycles < 0) begin
            @(negedge clock);
            bus.run = 1'b0; bus.mem_ready = 1'b1;
            #1;
            checkOutput({tag, "_idle"}, st(0));
            checkRetired({tag, "_idle"});
        end
    endtask

    initial begin
        logic [5:0] illegalOps [4];
        logic [5:0] op, fn;
        int         pick;
        illegalOps[0] = 6'b111111; illegalOps[1] = 6'b010000;
        illegalOps[2] = 6'b000001; illegalOps[3] = 6'b110000;

        bus.run = 1'b1; bus.mem_ready = 1'b1; bus.zero = 1'b0;
        bus.instr_op = 6'b100011; bus.instr_fn = 6'd0;
        @(negedge clock); @(negedge clock);
        #1;
        checkOutput("reset", st(0));
        checkRetired("reset");
        @(negedge clock);
        reset = 1'b1; bus.run = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.mem_ready = 1'b1;
            #1;
            checkOutput("runLow", st(0));
        end

        planInstr(6'b000000, 6'b100000, 0, 0, 1'b0, 1'b0);
        applyStimulus("add", -1);
        planInstr(6'b000000, 6'b000010, 1, 0, 1'b0, 1'b0);
        applyStimulus("srl", -1);
        planInstr(6'b100011, 6'($urandom), 3, 2, 1'b0, 1'b0);
        applyStimulus("lw", -1);
        planInstr(6'b000100, 6'($urandom), 0, 0, 1'b1, 1'b0);
        applyStimulus("beqTaken", -1);
        planInstr(6'b000100, 6'($urandom), 0, 0, 1'b0, 1'b0);
        applyStimulus("beqNot", -1);
        planInstr(6'b000101, 6'($urandom), 0, 0, 1'b0, 1'b0);
        applyStimulus("bne", -1);
        planInstr(6'b111111, 6'($urandom), 0, 0, 1'b0, 1'b0);
        applyStimulus("illegal", -1);
        planInstr(6'b000000, 6'b001000, 0, 0, 1'b0, 1'b0);
        applyStimulus("jr", -1);
        planInstr(6'b000011, 6'($urandom), 0, 0, 1'b0, 1'b0);
        applyStimulus("jal", -1);
        planInstr(6'b001101, 6'($urandom), 2, 0, 1'b0, 1'b0);
        applyStimulus("ori", -1);
        planInstr(6'b101011, 6'($urandom), 0, 1, 1'b0, 1'b0);
        applyStimulus("sw", -1);

        for (int k = 0; k < 40; k++) begin
            pick = $urandom_range(0, 9);
            fn = 6'($urandom);
            case (pick)
                0: op = 6'b000000;
                1: begin op = 6'b000000; fn = 6'b001000; end
                2: op = 6'b000100;
                3: op = 6'b000101;
                4: op = 6'b000010;
                5: op = 6'b000011;
                6: op = 6'b100011;
                7: op = 6'b101011;
                8: op = {3'b001, 3'($urandom)};
                default: op = illegalOps[$urandom_range(0, 3)];
            endcase
            planInstr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'b1);
            applyStimulus("random", -1);
        end

        planInstr(6'b101011, 6'($urandom), 0, 5, 1'b0, 1'b0);
        applyStimulus("swAbort", 5);
        plan.delete();
        #2;
        reset = 1'b0;
        #1;
        modelRetired = 32'd0;
        checkOutput("swAbortOut", st(0));
        checkRetired("swAbort");
        @(negedge clock); @(negedge clock);
        reset = 1'b1; bus.run = 1'b0; bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            checkOutput("postAbort", st(0));
            checkRetired("postAbort");
        end

        @(negedge clock);
        force dut.retired_q = 32'hFFFF_FFFF;
        @(posedge clock);
        #1;
        release dut.retired_q;
        modelRetired = 32'hFFFF_FFFF;
        checkRetired("preload");
        planInstr(6'b000010, 6'($urandom), 0, 0, 1'b0, 1'b0);
        applyStimulus("jWrap", -1);
        checks++;
        assert (bus.retired === 32'd0)
        else begin
            errors++;
            $error("[TB] FAIL wrap: observed %h expected %h", bus.retired, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
